// File: rtl/rgb_pwm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rgb_pwm_ctrl
// Brief  : N-channel PWM LED controller, shadowed duty, static/blink/breathe/off
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module rgb_pwm_ctrl #(
    parameter int N_CH      = 3,
    parameter int DUTY_W    = 8,
    parameter int PRESC     = 16,
    parameter int BLINK_PER = 64,
    parameter int RAMP_DIV  = 2
) (
    input  logic                   CLK100MHZ,
    input  logic                   CPU_RESETN,
    input  logic [N_CH*DUTY_W-1:0] duty_in,
    input  logic                   load,
    input  logic [N_CH-1:0]        ch_en,
    input  logic [1:0]             mode,
    output logic [N_CH-1:0]        pwm_out,
    output logic                   period_start
);

    localparam int PS_W = (PRESC > 1)     ? $clog2(PRESC)     : 1;
    localparam int BC_W = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
    localparam int RC_W = (RAMP_DIV > 1)  ? $clog2(RAMP_DIV)  : 1;

    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESC - 1);
    localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(BLINK_PER - 1);
    localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0] LVL_MAX  = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0] CNT_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};

    localparam logic [1:0] MODE_STATIC  = 2'b00;
    localparam logic [1:0] MODE_BLINK   = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_OFF     = 2'b11;

    localparam logic [2:0] ST_STATIC    = 3'd0;
    localparam logic [2:0] ST_BLINK_ON  = 3'd1;
    localparam logic [2:0] ST_BLINK_OFF = 3'd2;
    localparam logic [2:0] ST_BR_UP     = 3'd3;
    localparam logic [2:0] ST_BR_DOWN   = 3'd4;
    localparam logic [2:0] ST_OFF       = 3'd5;

    logic [PS_W-1:0]               presc;
    logic [DUTY_W-1:0]             cnt;
    logic                          step_tick;
    logic                          boundary;

    logic [N_CH-1:0][DUTY_W-1:0]   pending;
    logic [N_CH-1:0][DUTY_W-1:0]   active;
    logic [N_CH-1:0][DUTY_W-1:0]   deff;
    logic [N_CH-1:0][2*DUTY_W-1:0] prod;

    logic [2:0]                    state;
    logic [2:0]                    state_nxt;
    logic [1:0]                    cur_mode;
    logic [BC_W-1:0]               bcnt;
    logic [BC_W-1:0]               bcnt_nxt;
    logic [RC_W-1:0]               rcnt;
    logic [RC_W-1:0]               rcnt_nxt;
    logic [DUTY_W-1:0]             lvl;
    logic [DUTY_W-1:0]             lvl_nxt;

    assign step_tick = (presc == PS_LAST);
    assign boundary  = step_tick && (cnt == CNT_LAST);

    // Timebase: prescaler feeding a counter over 0..2^DUTY_W-2
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= step_tick ? '0 : presc + PS_W'(1);
            if (step_tick) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + DUTY_W'(1);
            end
        end
    end

    // Shadow registers: a load in the boundary cycle lands after active samples pending
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pending <= '0;
            active  <= '0;
        end else begin
            if (load) begin
                pending <= duty_in;
            end
            if (boundary) begin
                active <= pending;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state <= ST_STATIC;
            bcnt  <= '0;
            rcnt  <= '0;
            lvl   <= '0;
        end else if (boundary) begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            rcnt  <= rcnt_nxt;
            lvl   <= lvl_nxt;
        end
    end

    always_comb begin
        case (state)
            ST_STATIC:               cur_mode = MODE_STATIC;
            ST_BLINK_ON,
            ST_BLINK_OFF:            cur_mode = MODE_BLINK;
            ST_BR_UP,
            ST_BR_DOWN:              cur_mode = MODE_BREATHE;
            default:                 cur_mode = MODE_OFF;
        endcase
    end

    // A mode change always wins over blink toggles and ramp reversals
    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        rcnt_nxt  = rcnt;
        lvl_nxt   = lvl;
        if (mode != cur_mode) begin
            bcnt_nxt = '0;
            rcnt_nxt = '0;
            lvl_nxt  = '0;
            case (mode)
                MODE_STATIC:  state_nxt = ST_STATIC;
                MODE_BLINK:   state_nxt = ST_BLINK_ON;
                MODE_BREATHE: state_nxt = ST_BR_UP;
                default:      state_nxt = ST_OFF;
            endcase
        end else begin
            case (state)
                ST_BLINK_ON, ST_BLINK_OFF: begin
                    if (bcnt == BC_LAST) begin
                        bcnt_nxt  = '0;
                        state_nxt = (state == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
                    end else begin
                        bcnt_nxt = bcnt + BC_W'(1);
                    end
                end
                ST_BR_UP: begin
                    if (rcnt == RC_LAST) begin
                        rcnt_nxt = '0;
                        lvl_nxt  = lvl + DUTY_W'(1);
                        if (lvl_nxt == LVL_MAX) begin
                            state_nxt = ST_BR_DOWN;
                        end
                    end else begin
                        rcnt_nxt = rcnt + RC_W'(1);
                    end
                end
                ST_BR_DOWN: begin
                    if (rcnt == RC_LAST) begin
                        rcnt_nxt = '0;
                        lvl_nxt  = lvl - DUTY_W'(1);
                        if (lvl_nxt == '0) begin
                            state_nxt = ST_BR_UP;
                        end
                    end else begin
                        rcnt_nxt = rcnt + RC_W'(1);
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_prod
            assign prod[i] = {{DUTY_W{1'b0}}, active[i]} * {{DUTY_W{1'b0}}, lvl};
        end
    endgenerate

    always_comb begin
        deff = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (state)
                ST_STATIC, ST_BLINK_ON: deff[i] = active[i];
                ST_BR_UP, ST_BR_DOWN:   deff[i] = prod[i][2*DUTY_W-1 -: DUTY_W];
                default:                deff[i] = '0;
            endcase
        end
    end

    // cnt never reaches 2^DUTY_W-1, so full-scale duty stays high across the wrap
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            for (int i = 0; i < N_CH; i++) begin
                pwm_out[i] <= ch_en[i] & (cnt < deff[i]);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/rgb_pwm_ctrl.md
# rgb_pwm_ctrl

Parametrised N-channel PWM LED controller for the RGB LEDs and LED banks on the board. Each channel has its own duty value. A shadow register gives glitch-free duty updates at period boundaries. A small mode FSM adds static, blink, breathe (triangular fade) and off modes. It sits between switch/UART-driven configuration logic and the LED output pins.

## Interface
- N_CH, 3: number of PWM channels.
- DUTY_W, 8: duty resolution in bits. The PWM period is 2^DUTY_W-1 steps.
- PRESC, 16: clock cycles per PWM step (≥1).
- BLINK_PER, 64: PWM periods per blink half-cycle (≥1).
- RAMP_DIV, 2: PWM periods per breathe level step (≥1).

Ports:
- CLK100MHZ  in  1  system clock. One clock domain.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- duty_in  in  N_CH*DUTY_W  requested duty. Channel i is at [i*DUTY_W +: DUTY_W].
- load  in  1  one-cycle strobe that captures duty_in into the pending register.
- ch_en  in  N_CH  per-channel enable.
- mode  in  2  operating mode: 00 static, 01 blink, 10 breathe, 11 off.
- pwm_out  out  N_CH  registered PWM outputs.
- period_start  out  1  one-cycle pulse at each PWM period boundary.

## Operation
- Prescaler: presc counts 0..PRESC-1. A step tick occurs when presc==PRESC-1.
- PWM counter: cnt advances on each step tick over 0..2^DUTY_W-2, then wraps to 0.
- Boundary: a step tick with cnt==2^DUTY_W-2. At the boundary the block does all of the following:
  - active[i] <= pending[i].
  - Mode FSM state updates.
  - Blink and breathe counters advance.
- load captures duty_in into pending on the clock edge. A load in the boundary cycle is not applied at that boundary. pending holds the pre-load value at that edge, and the new value takes effect at the following boundary.
- Effective duty deff[i] by mode:
  - static: deff = active.
  - blink: deff = active in BLINK_ON, 0 in BLINK_OFF.
  - breathe: deff = (active*lvl) >> DUTY_W, using a 2*DUTY_W-bit product and keeping the upper DUTY_W bits.
  - off: deff = 0.
- Compare: pwm_out[i] <= ch_en[i] & (cnt < deff[i]).
  - deff=0 gives constant low.
  - deff=2^DUTY_W-1 gives constant high, with no glitch at the wrap.
- Mode FSM states: STATIC, BLINK_ON, BLINK_OFF, BREATHE_UP, BREATHE_DOWN, OFF. The mode input is sampled only at boundaries.
  - Entering blink goes to BLINK_ON with bcnt=0. bcnt counts periods. At bcnt==BLINK_PER-1 the state toggles ON↔OFF and bcnt clears.
  - Entering breathe goes to BREATHE_UP with lvl=0 and rcnt=0.
    - Every RAMP_DIV periods, lvl steps by ±1.
    - In UP, when lvl reaches 2^DUTY_W-1 the state goes to DOWN.
    - In DOWN, when lvl reaches 0 the state goes to UP.
    - lvl never wraps.
  - Staying in the same mode keeps the counters running. Any mode change resets bcnt, rcnt and lvl.
  - mode 11 goes to OFF.
- ch_en is not shadowed. It gates the output on the next clock edge.

## Timing
- Period = PRESC*(2^DUTY_W-1) clocks. Channel i is high for exactly deff[i]*PRESC clocks per period, starting at the first clock of the period.
- period_start is registered and high for one clock, in the cycle after the boundary edge, aligned with cnt==0.
  - The first pulse comes PRESC*(2^DUTY_W-1) clocks after CPU_RESETN rises.
- pwm_out latency: one clock after cnt/deff.
- Reset (asynchronous, any time, including mid-period): the following take effect immediately, without waiting for a clock:
  - pwm_out=0 and period_start=0.
  - presc, cnt, bcnt, rcnt and lvl = 0.
  - active and pending = 0.
  - FSM = STATIC.
- Outputs stay low after reset release until a load and the boundary that follows it.
- Simultaneous events at one boundary:
  - load and boundary: the old pending is applied.
  - mode change and blink toggle: the mode change wins.
  - lvl max and mode change: the mode change wins.

## Test plan
All tests use N_CH=3, DUTY_W=4, PRESC=2, BLINK_PER=2, RAMP_DIV=1, so a period is 30 clocks.
1. Static: duty_in={0,15,5} (ch2,ch1,ch0), ch_en=111, load once, mode 00. After the second period_start, measure one period. Required: ch0 high 10/30 clocks, ch1 high 30/30, ch2 high 0/30, and period_start exactly every 30 clocks.
2. Shadow update: ch0 running at 5, load duty 12 at cnt=7. Required: the current period stays 10 clocks high, the next period is 24 clocks high, with no runt pulse.
3. Enable mask: ch_en 111→101 mid-period. Required: ch1 low on the next clock, ch0 and ch2 unaffected.
4. Blink: ch0 duty 15, mode 01. Required: ch0 high 60 clocks, then low 60 clocks, repeating.
5. Breathe: ch0 duty 15, mode 10. Required: per-period high time tracks ((15*lvl)>>4)*2 clocks as lvl goes 0,1,…,15,14,…,0,1. The peak period is 28 clocks, and the level reverses at 15 and at 0 with no wrap.
6. Reset mid-operation: pull CPU_RESETN low at cnt=9 while outputs are high. Required: all pwm_out=0 immediately, with no clock needed. After release: outputs stay low across two periods with no load, and the first period_start arrives 30 clocks after release.
